// File: rtl/elastic_fork_buffered_pkg.sv
// Shared definitions for the elastic stream modules.
// Handshake is stop-based: a transfer happens when valid=1 and stop=0.
package elastic_fork_buffered_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int NEIGHBOR_PE_NUM = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    data_t data;
    logic  valid;
  } handshake_t;

endpackage

// File: rtl/elastic_branch_fifo.sv
// Single-clock circular-buffer FIFO for one fork branch.
// Flush beats push/pop; storage itself is never reset.
module elastic_branch_fifo
  import elastic_fork_buffered_pkg::*;
#(
  parameter  int DATA_WIDTH = elastic_fork_buffered_pkg::DATA_WIDTH,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/elastic_fork_buffered.sv
// Replicates one elastic stream to NUM_OUT branches, each decoupled by its own FIFO.
// Back-pressure comes only from registered FIFO fullness, never from stop_output.
module elastic_fork_buffered
  import elastic_fork_buffered_pkg::*;
#(
  parameter  int DATA_WIDTH = elastic_fork_buffered_pkg::DATA_WIDTH,
  parameter  int NUM_OUT    = NEIGHBOR_PE_NUM,
  parameter  int DEPTH      = 2,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               flush,
  input  logic [NUM_OUT-1:0]                 enable_mask,
  input  logic [DATA_WIDTH-1:0]              input_data,
  input  logic                               valid_input,
  output logic                               stop_input,
  output logic [NUM_OUT-1:0][DATA_WIDTH-1:0] output_data,
  output logic [NUM_OUT-1:0]                 valid_output,
  input  logic [NUM_OUT-1:0]                 stop_output,
  output logic [NUM_OUT-1:0][CNT_W-1:0]      occupancy,
  output logic                               idle
);

  logic [NUM_OUT-1:0] full;
  logic [NUM_OUT-1:0] empty;
  logic               accept;

  assign stop_input = |(enable_mask & full);
  assign accept     = valid_input && !stop_input;
  assign idle       = &empty;

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_branch
    // Gating with valid keeps an X stop on an empty branch out of the pop.
    elastic_branch_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .push      (accept && enable_mask[i]),
      .push_data (input_data),
      .pop       (valid_output[i] && !stop_output[i]),
      .head_data (output_data[i]),
      .full      (full[i]),
      .empty     (empty[i]),
      .count     (occupancy[i])
    );
    assign valid_output[i] = !empty[i];
  end

endmodule

// File: tb/tb_elastic_fork_buffered.sv
// Bench for elastic_fork_buffered: queue-based branch model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_elastic_fork_buffered;

  localparam int DW = 32;
  localparam int NO = 4;
  localparam int DP = 2;
  localparam int CW = $clog2(DP + 1);

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic [NO-1:0]          enable_mask;
  logic [DW-1:0]          input_data;
  logic                   valid_input;
  logic                   stop_input;
  logic [NO-1:0][DW-1:0]  output_data;
  logic [NO-1:0]          valid_output;
  logic [NO-1:0]          stop_output;
  logic [NO-1:0][CW-1:0]  occupancy;
  logic                   idle;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q [NO][$];
  logic [NO-1:0] prev_mask;

  elastic_fork_buffered #(.DATA_WIDTH(DW), .NUM_OUT(NO), .DEPTH(DP)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .enable_mask  (enable_mask),
    .input_data   (input_data),
    .valid_input  (valid_input),
    .stop_input   (stop_input),
    .output_data  (output_data),
    .valid_output (valid_output),
    .stop_output  (stop_output),
    .occupancy    (occupancy),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_stop();
    logic s = 1'b0;
    for (int i = 0; i < NO; i++)
      if (enable_mask[i] && q[i].size() == DP) s = 1'b1;
    return s;
  endfunction

  function automatic logic model_idle();
    logic e = 1'b1;
    for (int i = 0; i < NO; i++)
      if (q[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  always @(negedge reset_n)
    for (int i = 0; i < NO; i++) q[i].delete();

  // Reference: per-branch token queues updated from the transfer rules.
  always @(posedge clk) begin
    if (reset_n) begin
      if (enable_mask !== prev_mask && !model_idle())
        chk("mask_stable_while_busy", enable_mask, prev_mask);
      if (flush) begin
        for (int i = 0; i < NO; i++) q[i].delete();
      end else begin
        logic acc;
        acc = valid_input && !model_stop();
        for (int i = 0; i < NO; i++) begin
          if (q[i].size() > 0 && stop_output[i] === 1'b0) void'(q[i].pop_front());
          if (acc && enable_mask[i]) q[i].push_back(input_data);
        end
      end
    end
    prev_mask <= enable_mask;
  end

  always @(negedge clk) begin
    chk("stop_input", stop_input, model_stop());
    chk("idle", idle, model_idle());
    for (int i = 0; i < NO; i++) begin
      chk($sformatf("valid_output[%0d]", i), valid_output[i], q[i].size() != 0);
      chk($sformatf("occupancy[%0d]", i), occupancy[i], q[i].size());
      if (q[i].size() != 0)
        chk($sformatf("output_data[%0d]", i), output_data[i], q[i][0]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] toks [4];
    int n;
    toks[0] = 32'h1000_0001; toks[1] = 32'h2000_0002;
    toks[2] = 32'h3000_0003; toks[3] = 32'h4000_0004;
    reset_n = 1'b0; flush = 1'b0; enable_mask = 4'hf; prev_mask = 4'hf;
    input_data = '0; valid_input = 1'b0; stop_output = '0;
    cyc();
    chk("reset_idle", idle, 1'b1);
    chk("reset_valid", valid_output, 4'h0);
    chk("reset_stop", stop_input, 1'b0);
    reset_n = 1'b1;
    cyc();

    // Stream 0x11, 0x22, 0x33 to all branches.
    valid_input = 1'b1;
    input_data = 32'h11; cyc();
    chk("s1_valid", valid_output, 4'hf);
    for (int i = 0; i < NO; i++) chk("s1_data_11", output_data[i], 32'h11);
    input_data = 32'h22; cyc();
    for (int i = 0; i < NO; i++) chk("s1_data_22", output_data[i], 32'h22);
    input_data = 32'h33; cyc();
    for (int i = 0; i < NO; i++) chk("s1_data_33", output_data[i], 32'h33);
    chk("s1_stop", stop_input, 1'b0);
    valid_input = 1'b0; cyc(); cyc();

    // Branch 1 stalled: fills after two accepts.
    stop_output = 4'b0010;
    valid_input = 1'b1; input_data = toks[0]; cyc();
    input_data = toks[1]; cyc();
    chk("s2_stop_full", stop_input, 1'b1);
    chk("s2_occ1", occupancy[1], 2);
    chk("s2_occ0", occupancy[0], 1);
    input_data = toks[2]; cyc();
    chk("s2_occ0_drained", occupancy[0], 0);
    chk("s2_head1", output_data[1], toks[0]);
    stop_output = 4'b0000;
    n = 2;
    for (int k = 0; k < 20 && n < 4; k++) begin
      logic acc;
      input_data = toks[n];
      acc = !stop_input;
      cyc();
      if (acc) n++;
    end
    chk("s2_all_accepted", n, 4);
    valid_input = 1'b0; cyc(); cyc(); cyc();

    // Partial mask, X stop on a disabled branch.
    enable_mask = 4'b0101; stop_output = 4'b0000; stop_output[1] = 1'bx;
    valid_input = 1'b1; input_data = 32'hA5; cyc();
    chk("s3_valid", valid_output, 4'b0101);
    chk("s3_data0", output_data[0], 32'hA5);
    chk("s3_data2", output_data[2], 32'hA5);
    chk("s3_occ1", occupancy[1], 0);
    chk("s3_occ3", occupancy[3], 0);
    chk("s3_stop", stop_input, 1'b0);
    valid_input = 1'b0; cyc();
    stop_output = 4'b0000; cyc();

    // No branch enabled: tokens are discarded.
    enable_mask = 4'b0000; valid_input = 1'b1;
    for (int k = 0; k < 3; k++) begin
      input_data = 32'hC0 + k; cyc();
      chk("s4_stop", stop_input, 1'b0);
      chk("s4_valid", valid_output, 4'h0);
      chk("s4_idle", idle, 1'b1);
    end
    valid_input = 1'b0; cyc();

    // Fill branch 2, then flush with a token presented.
    enable_mask = 4'hf; stop_output = 4'b0100; valid_input = 1'b1;
    input_data = 32'hB1; cyc();
    input_data = 32'hB2; cyc();
    chk("s5_occ2_full", occupancy[2], DP);
    flush = 1'b1; input_data = 32'hEE; cyc();
    flush = 1'b0; valid_input = 1'b0;
    chk("s5_idle", idle, 1'b1);
    chk("s5_occ", occupancy, '0);
    chk("s5_valid", valid_output, 4'h0);
    stop_output = 4'b0000; cyc();

    // Asynchronous reset in the middle of a cycle.
    stop_output = 4'hf; valid_input = 1'b1; input_data = 32'hD1; cyc();
    valid_input = 1'b0;
    chk("s6_pre_occ0", occupancy[0], 1);
    @(posedge clk); #2;
    reset_n = 1'b0; #1;
    chk("s6_async_valid", valid_output, 4'h0);
    chk("s6_async_occ", occupancy, '0);
    chk("s6_async_idle", idle, 1'b1);
    cyc();
    reset_n = 1'b1; stop_output = 4'h0; cyc();
    valid_input = 1'b1; input_data = 32'h77; cyc();
    chk("s6_after_valid", valid_output, 4'hf);
    chk("s6_after_data", output_data[3], 32'h77);
    valid_input = 1'b0; cyc(); cyc();

    // Randomized traffic; mask only changes once drained.
    for (int r = 0; r < 30; r++) begin
      for (int k = 0; k < 60; k++) begin
        valid_input = ($urandom_range(0, 3) != 0);
        input_data  = $urandom;
        stop_output = NO'($urandom);
        flush       = ($urandom_range(0, 49) == 0);
        cyc();
      end
      valid_input = 1'b0; flush = 1'b0; stop_output = '0;
      n = 0;
      while (!idle && n < 10) begin cyc(); n++; end
      chk("drain_to_idle", idle, 1'b1);
      enable_mask = NO'($urandom_range(0, 15));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_fork_buffered.md
Name: elastic_fork_buffered

Overview:
- Parametrised successor to the single-stage elastic fork.
- Replicates one elastic input stream to NUM_OUT output channels. Each channel has its own FIFO of depth DEPTH, so a stalled consumer no longer blocks the other branches until its FIFO fills.
- A runtime enable mask, driven from the PE configuration, selects which branches participate. A synchronous flush empties all FIFOs.
- Sits between a PE output register and the switch/neighbour links of the CGRA.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- NUM_OUT, 4, number of output branches (>=1; default matches the neighbour PE count).
- DEPTH, 2, entries per branch FIFO (>=1; >=2 required for full throughput).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all branch FIFOs.
- enable_mask  input  NUM_OUT  per-branch participation; static while not idle.
- input_data  input  DATA_WIDTH  payload.
- valid_input  input  1  payload present.
- stop_input  output  1  back-pressure to producer.
- output_data  output  NUM_OUT x DATA_WIDTH  per-branch FIFO head.
- valid_output  output  NUM_OUT  per-branch head valid.
- stop_output  input  NUM_OUT  per-branch back-pressure from consumer.
- occupancy  output  NUM_OUT x CNT_W  per-branch entry count.
- idle  output  1  all FIFOs empty.

Behaviour:
- Handshake convention (stop-based):
  - Input transfer occurs in a cycle with valid_input=1 and stop_input=0.
  - Branch i transfer occurs in a cycle with valid_output[i]=1 and stop_output[i]=0.
- stop_input = OR over i of (enable_mask[i] & full[i]).
  - Depends only on registered FIFO state and enable_mask.
  - There is no combinational path from stop_output to stop_input. A push into a full FIFO in the same cycle as its pop is not allowed.
- On input transfer, input_data is written into every enabled branch FIFO in the same cycle. Disabled branches are untouched.
- If enable_mask is all zero, stop_input=0 and accepted tokens are discarded.
- Latency is 1 cycle: a token accepted at edge N appears on valid_output/output_data after edge N. There is no combinational bypass.
- valid_output[i] = !empty[i]. output_data[i] = head entry of FIFO i, stable while valid_output[i]=1 and stop_output[i]=1.
- On branch i transfer, the FIFO head is popped. Push and pop in the same cycle leave occupancy unchanged; this is legal whenever the FIFO is not full.
- Per-branch FIFO: circular buffer with rd/wr pointers wrapping at DEPTH (DEPTH need not be a power of two) plus a CNT_W-bit counter.
  - full = (count==DEPTH); empty = (count==0).
- Throughput: DEPTH>=2 sustains 1 token/cycle with all consumers ready. DEPTH=1 gives at most 1 token per 2 cycles.
- Ordering: each branch delivers tokens in input order. Branches are mutually decoupled up to DEPTH tokens of skew.
- flush (synchronous, highest priority):
  - Next edge sets all counts and pointers to 0.
  - Same-cycle pushes and pops are ignored.
  - stop_input is unaffected combinationally in the flush cycle.
- Reset (asynchronous, mid-operation allowed): all pointers and counts go to 0 immediately, so valid_output=0, stop_input=0, occupancy=0 and idle=1 while reset_n=0. FIFO storage is not reset; output_data is don't-care while invalid.
- enable_mask changes are defined only when idle=1. A bench assertion flags a change while idle=0.
- idle = AND over all branches of empty[i], including disabled branches.
- X on stop_output of a disabled or empty branch must not propagate to stop_input.

Decomposition:
- Shared package gets: DATA_WIDTH and NEIGHBOR_PE_NUM (default for NUM_OUT), a typedef for the data word, and the stop-convention handshake struct (data, valid) reused by the elastic modules.
- One sub-module: elastic_branch_fifo. It is a single-clock FIFO with push/pop, full/empty/count, and the flush and async reset behaviour described above. The top level instantiates NUM_OUT copies in a generate loop plus the mask/stop OR tree.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with all enabled and stop_output=0 -> each branch shows 0x11,0x22,0x33 on consecutive cycles, 1 cycle after acceptance; stop_input stays 0.
- DEPTH=2: hold stop_output[1]=1 and send 4 tokens -> after 2 accepts stop_input=1; branches 0,2,3 drain 2 tokens; release stop_output[1] -> remaining 2 tokens accepted; all branches end with 4 tokens in order.
- enable_mask=4'b0101 and send 0xA5 -> only branches 0 and 2 assert valid with 0xA5; occupancy[1]=occupancy[3]=0; stop_output[1]=X causes no stop_input change.
- enable_mask=0 with valid_input=1 for 3 cycles -> stop_input=0 throughout; no valid_output; idle stays 1.
- Fill branch 2 to DEPTH, then assert flush concurrent with valid_input=1 -> next cycle all occupancy=0 and idle=1; the flush-cycle token appears nowhere.
- Assert reset_n=0 asynchronously mid-stream with FIFOs partially full -> valid_output=0 and occupancy=0 before the next clk edge; after release, the first new token appears normally.
